// File: rtl/alu_reservation_station_pkg.sv
// Shared definitions for the ALU reservation station.
//   - Default ROB id and ALU opcode widths.
//   - ALU opcode encodings (arithmetic, logic, shifts, compares, branches).
//   - rs_entry_t: one reservation-station slot. Its field widths come from the
//     package defaults, so the top-level ROB_W / OP_W must keep those values.
package alu_reservation_station_pkg;

    localparam int ROB_W_DEF = 5;
    localparam int OP_W_DEF  = 4;

    localparam logic [OP_W_DEF-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W_DEF-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W_DEF-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W_DEF-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W_DEF-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W_DEF-1:0] ALU_SLL  = 4'd5;
    localparam logic [OP_W_DEF-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W_DEF-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W_DEF-1:0] ALU_SLT  = 4'd8;
    localparam logic [OP_W_DEF-1:0] ALU_SLTU = 4'd9;
    localparam logic [OP_W_DEF-1:0] ALU_BEQ  = 4'd10;
    localparam logic [OP_W_DEF-1:0] ALU_BNE  = 4'd11;
    localparam logic [OP_W_DEF-1:0] ALU_BLT  = 4'd12;
    localparam logic [OP_W_DEF-1:0] ALU_BGE  = 4'd13;
    localparam logic [OP_W_DEF-1:0] ALU_BLTU = 4'd14;
    localparam logic [OP_W_DEF-1:0] ALU_BGEU = 4'd15;

    typedef struct packed {
        logic                 busy;
        logic [ROB_W_DEF-1:0] rob_id;
        logic [OP_W_DEF-1:0]  op;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic [ROB_W_DEF-1:0] qj;
        logic [ROB_W_DEF-1:0] qk;
        logic                 pj;
        logic                 pk;
    } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_pick_lowest.sv
// rs_pick_lowest: priority encoder returning the lowest set bit of vec.
//   vec   in  N      request bits
//   found out 1      at least one bit set
//   index out IDX_W  index of the lowest set bit (0 when none)
module rs_pick_lowest #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: out-of-order issue buffer in front of the ALU.
//   clk_in, rst_in (sync, active-low), rdy_in (pause), _clear (flush), _stall
//   _issue_*      new decoded instruction with renamed operands
//   _rs_full      no free slot; issue must not be driven while high
//   _alu_full     ALU back-pressure
//   _alu_*        registered dispatch outputs, _alu_ready one pulse per instr
//   _cdb_*        common data bus broadcast, snooped every cycle
//
// Dispatch handshake: _alu_ready is a valid pulse. An instruction is handed
// over on an edge where a ready entry exists and _alu_full and _stall are both
// low; the ALU accepts every pulse. _alu_full is the ALU's ready, inverted, and
// is only consulted when choosing whether to dispatch on the next edge.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int OP_W    = OP_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _stall,
    input  logic             _issue_valid,
    input  logic [ROB_W-1:0] _issue_rob_id,
    input  logic [OP_W-1:0]  _issue_op,
    input  logic [31:0]      _issue_vj,
    input  logic [31:0]      _issue_vk,
    input  logic [ROB_W-1:0] _issue_qj,
    input  logic [ROB_W-1:0] _issue_qk,
    input  logic             _issue_pj,
    input  logic             _issue_pk,
    output logic             _rs_full,
    input  logic             _alu_full,
    output logic             _alu_ready,
    output logic [ROB_W-1:0] _alu_rob_id,
    output logic [OP_W-1:0]  _alu_op,
    output logic [31:0]      _alu_vj,
    output logic [31:0]      _alu_vk,
    input  logic             _cdb_ready,
    input  logic [ROB_W-1:0] _cdb_rob_id,
    input  logic [31:0]      _cdb_value
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t entries [RS_SIZE];
    rs_entry_t new_entry;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               ready_found;
    logic [IDX_W-1:0]   ready_idx;
    logic               issue_fire;
    logic               dispatch_fire;

    // All selection uses registered state, so a wake-up at edge E is only
    // visible to dispatch at E+1 and a freed slot is reusable one cycle later.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries[i].busy;
            ready_vec[i] = entries[i].busy && !entries[i].pj && !entries[i].pk;
        end
    end

    assign free_vec      = ~busy_vec;
    assign _rs_full      = &busy_vec;
    assign issue_fire    = _issue_valid && !_rs_full;
    assign dispatch_fire = ready_found && !_alu_full && !_stall;

    rs_pick_lowest #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
        .vec   (free_vec),
        .found (free_found),
        .index (free_idx)
    );

    rs_pick_lowest #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
        .vec   (ready_vec),
        .found (ready_found),
        .index (ready_idx)
    );

    // Incoming entry, with same-cycle CDB forwarding so an operand broadcast
    // while its consumer is being issued is not missed.
    always_comb begin
        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.rob_id = _issue_rob_id;
        new_entry.op     = _issue_op;
        new_entry.vj     = _issue_vj;
        new_entry.vk     = _issue_vk;
        new_entry.qj     = _issue_qj;
        new_entry.qk     = _issue_qk;
        new_entry.pj     = _issue_pj;
        new_entry.pk     = _issue_pk;
        if (_cdb_ready && _issue_pj && (_cdb_rob_id == _issue_qj)) begin
            new_entry.vj = _cdb_value;
            new_entry.pj = 1'b0;
        end
        if (_cdb_ready && _issue_pk && (_cdb_rob_id == _issue_qk)) begin
            new_entry.vk = _cdb_value;
            new_entry.pk = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i] <= '0;
            end
            _alu_ready  <= 1'b0;
            _alu_rob_id <= '0;
            _alu_op     <= '0;
            _alu_vj     <= '0;
            _alu_vk     <= '0;
        end else if (!rdy_in) begin
            // Entries hold; dropping the pulse keeps the last dispatch from
            // being seen again while the CPU is paused.
            _alu_ready <= 1'b0;
        end else if (_clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries[i].busy <= 1'b0;
            end
            _alu_ready <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (_cdb_ready && entries[i].busy) begin
                    if (entries[i].pj && (entries[i].qj == _cdb_rob_id)) begin
                        entries[i].vj <= _cdb_value;
                        entries[i].pj <= 1'b0;
                    end
                    if (entries[i].pk && (entries[i].qk == _cdb_rob_id)) begin
                        entries[i].vk <= _cdb_value;
                        entries[i].pk <= 1'b0;
                    end
                end
            end

            if (dispatch_fire) begin
                _alu_ready             <= 1'b1;
                _alu_rob_id            <= entries[ready_idx].rob_id;
                _alu_op                <= entries[ready_idx].op;
                _alu_vj                <= entries[ready_idx].vj;
                _alu_vk                <= entries[ready_idx].vk;
                entries[ready_idx].busy <= 1'b0;
            end else begin
                _alu_ready <= 1'b0;
            end

            // The issue slot is free and the dispatch slot is busy, so these
            // two writes never target the same entry.
            if (issue_fire && free_found) begin
                entries[free_idx] <= new_entry;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a vector table of single
// instructions (with and without issue-cycle forwarding) followed by
// hand-written sequences for wake-up, full, back-pressure, flush and pause.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rob_id = '0;
    logic [3:0]  issue_op = '0;
    logic [31:0] issue_vj = '0;
    logic [31:0] issue_vk = '0;
    logic [4:0]  issue_qj = '0;
    logic [4:0]  issue_qk = '0;
    logic        issue_pj = 1'b0;
    logic        issue_pk = 1'b0;
    logic        rs_full;
    logic        alu_full = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rob_id;
    logic [3:0]  alu_op;
    logic [31:0] alu_vj;
    logic [31:0] alu_vk;
    logic        cdb_ready = 1'b0;
    logic [4:0]  cdb_rob_id = '0;
    logic [31:0] cdb_value = '0;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    alu_reservation_station dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .rdy_in       (rdy),
        ._clear       (clear),
        ._stall       (stall),
        ._issue_valid (issue_valid),
        ._issue_rob_id(issue_rob_id),
        ._issue_op    (issue_op),
        ._issue_vj    (issue_vj),
        ._issue_vk    (issue_vk),
        ._issue_qj    (issue_qj),
        ._issue_qk    (issue_qk),
        ._issue_pj    (issue_pj),
        ._issue_pk    (issue_pk),
        ._rs_full     (rs_full),
        ._alu_full    (alu_full),
        ._alu_ready   (alu_ready),
        ._alu_rob_id  (alu_rob_id),
        ._alu_op      (alu_op),
        ._alu_vj      (alu_vj),
        ._alu_vk      (alu_vk),
        ._cdb_ready   (cdb_ready),
        ._cdb_rob_id  (cdb_rob_id),
        ._cdb_value   (cdb_value)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [4:0] rob, input logic [3:0] op,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic pj, input logic [4:0] qj,
                               input logic pk, input logic [4:0] qk);
        issue_valid  = 1'b1;
        issue_rob_id = rob;
        issue_op     = op;
        issue_vj     = vj;
        issue_vk     = vk;
        issue_pj     = pj;
        issue_qj     = qj;
        issue_pk     = pk;
        issue_qk     = qk;
    endtask

    task automatic drive_cdb(input logic [4:0] tag, input logic [31:0] val);
        cdb_ready  = 1'b1;
        cdb_rob_id = tag;
        cdb_value  = val;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        cdb_ready   = 1'b0;
        clear       = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Check that a dispatch is visible now and matches the head of exp_q.
    task automatic chk_dispatch_head(input string name);
        logic [4:0] exp_rob;
        chk({name, "_ready"}, {31'd0, alu_ready}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_queue actual=empty required=entry", name);
        end else begin
            exp_rob = exp_q.pop_front();
            chk({name, "_rob"}, {27'd0, alu_rob_id}, {27'd0, exp_rob});
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  rob;
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic        pj;
        logic [4:0]  qj;
        logic        pk;
        logic [4:0]  qk;
        logic        cdb_rdy;
        logic [4:0]  cdb_tag;
        logic [31:0] cdb_val;
        logic [31:0] exp_vj;
        logic [31:0] exp_vk;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{5'd3,  ALU_ADD, 32'd5,        32'd7,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    32'd5,        32'd7};
        vecs[1] = '{5'd7,  ALU_SUB, 32'hFFFFFFFF, 32'd1,  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,    32'hFFFFFFFF, 32'd1};
        vecs[2] = '{5'd8,  ALU_XOR, 32'h0,        32'h55, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd2, 32'h1234, 32'h1234,     32'h55};
        vecs[3] = '{5'd9,  ALU_SLT, 32'hA,        32'h0,  1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 5'd6, 32'hBEEF, 32'hA,        32'hBEEF};
        vecs[4] = '{5'd31, ALU_SRA, 32'h0,        32'h0,  1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd4, 32'hCAFE, 32'hCAFE,     32'hCAFE};
        vecs[5] = '{5'd0,  ALU_AND, 32'h11,       32'h22, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 32'hDEAD, 32'h11,       32'h22};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        step();
        step();
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_rs_full",   {31'd0, rs_full},   32'd0);
        chk("rst_rob",       {27'd0, alu_rob_id}, 32'd0);
        chk("rst_op",        {28'd0, alu_op},     32'd0);
        chk("rst_vj",        alu_vj,              32'd0);
        chk("rst_vk",        alu_vk,              32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- table: issue, 2-edge latency, one pulse ----------------
        for (int v = 0; v < 6; v++) begin
            drive_issue(vecs[v].rob, vecs[v].op, vecs[v].vj, vecs[v].vk,
                        vecs[v].pj, vecs[v].qj, vecs[v].pk, vecs[v].qk);
            if (vecs[v].cdb_rdy) drive_cdb(vecs[v].cdb_tag, vecs[v].cdb_val);
            step();
            idle();
            chk($sformatf("v%0d_lat1", v), {31'd0, alu_ready}, 32'd0);
            step();
            chk($sformatf("v%0d_ready", v), {31'd0, alu_ready}, 32'd1);
            chk($sformatf("v%0d_rob", v),   {27'd0, alu_rob_id}, {27'd0, vecs[v].rob});
            chk($sformatf("v%0d_op", v),    {28'd0, alu_op},     {28'd0, vecs[v].op});
            chk($sformatf("v%0d_vj", v),    alu_vj, vecs[v].exp_vj);
            chk($sformatf("v%0d_vk", v),    alu_vk, vecs[v].exp_vk);
            step();
            chk($sformatf("v%0d_pulse", v), {31'd0, alu_ready}, 32'd0);
        end

        // ---------------- dependent operand woken by later broadcast ----------------
        drive_issue(5'd4, ALU_OR, 32'h0, 32'd9, 1'b1, 5'd2, 1'b0, 5'd0);
        step();
        idle();
        step();
        chk("dep_wait1", {31'd0, alu_ready}, 32'd0);
        step();
        chk("dep_wait2", {31'd0, alu_ready}, 32'd0);
        drive_cdb(5'd2, 32'h1234);
        step();
        idle();
        chk("dep_woken_not_yet", {31'd0, alu_ready}, 32'd0);
        step();
        chk("dep_ready", {31'd0, alu_ready}, 32'd1);
        chk("dep_rob",   {27'd0, alu_rob_id}, 32'd4);
        chk("dep_vj",    alu_vj, 32'h1234);
        chk("dep_vk",    alu_vk, 32'd9);
        step();

        // ---------------- full ----------------
        for (int k = 0; k < 8; k++) begin
            drive_issue(5'(10 + k), ALU_ADD, 32'h0, 32'(k), 1'b1, 5'd9, 1'b0, 5'd0);
            exp_q.push_back(5'(10 + k));
            step();
            chk($sformatf("full_fill%0d_noready", k), {31'd0, alu_ready}, 32'd0);
        end
        idle();
        chk("full_flag", {31'd0, rs_full}, 32'd1);
        // A ready 9th instruction must be ignored while full.
        drive_issue(5'd20, ALU_ADD, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idle();
        chk("full_still", {31'd0, rs_full}, 32'd1);
        step();
        chk("full_no_dispatch", {31'd0, alu_ready}, 32'd0);
        drive_cdb(5'd9, 32'h99);
        step();
        idle();
        for (int k = 0; k < 8; k++) begin
            step();
            chk_dispatch_head($sformatf("full_d%0d", k));
            chk($sformatf("full_d%0d_vj", k), alu_vj, 32'h99);
            chk($sformatf("full_d%0d_vk", k), alu_vk, 32'(k));
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("full_no20_%0d", k), {31'd0, alu_ready}, 32'd0);
        end
        chk("full_empty_after", {31'd0, rs_full}, 32'd0);

        // ---------------- back-pressure: alu_full then stall ----------------
        for (int mode = 0; mode < 2; mode++) begin
            if (mode == 0) alu_full = 1'b1; else stall = 1'b1;
            drive_issue(5'd5, ALU_ADD, 32'd1, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            exp_q.push_back(5'd5);
            step();
            drive_issue(5'd6, ALU_ADD, 32'd2, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            exp_q.push_back(5'd6);
            step();
            idle();
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("bp%0d_hold%0d", mode, c), {31'd0, alu_ready}, 32'd0);
                step();
            end
            alu_full = 1'b0;
            stall    = 1'b0;
            step();
            chk_dispatch_head($sformatf("bp%0d_a", mode));
            chk($sformatf("bp%0d_a_vj", mode), alu_vj, 32'd1);
            step();
            chk_dispatch_head($sformatf("bp%0d_b", mode));
            chk($sformatf("bp%0d_b_vj", mode), alu_vj, 32'd2);
            step();
            chk($sformatf("bp%0d_done", mode), {31'd0, alu_ready}, 32'd0);
        end

        // ---------------- flush ----------------
        alu_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_issue(5'(21 + k), ALU_SUB, 32'(k), 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            step();
        end
        idle();
        alu_full = 1'b0;
        step();
        chk("clr_pre_ready", {31'd0, alu_ready}, 32'd1);
        chk("clr_pre_rob",   {27'd0, alu_rob_id}, 32'd21);
        clear = 1'b1;
        drive_issue(5'd25, ALU_ADD, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        idle();
        chk("clr_ready", {31'd0, alu_ready}, 32'd0);
        chk("clr_full",  {31'd0, rs_full},   32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("clr_none%0d", c), {31'd0, alu_ready}, 32'd0);
        end

        // ---------------- pause ----------------
        alu_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_issue(5'(26 + k), ALU_AND, 32'(100 + k), 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            exp_q.push_back(5'(26 + k));
            step();
        end
        idle();
        alu_full = 1'b0;
        step();
        chk_dispatch_head("pause_first");
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("pause_hold%0d", c), {31'd0, alu_ready}, 32'd0);
        end
        rdy = 1'b1;
        step();
        chk_dispatch_head("pause_resume_a");
        chk("pause_resume_a_vj", alu_vj, 32'd101);
        step();
        chk_dispatch_head("pause_resume_b");
        chk("pause_resume_b_vj", alu_vj, 32'd102);
        step();
        chk("pause_done", {31'd0, alu_ready}, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
